// File: rtl/trap_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// trap_sequencer_pkg
// Shared definitions for the trap sequencer: sequencer state encoding, trap
// target encoding, CSR addresses written during trap entry, bit positions
// inside mstatus/dcsr, and privilege encodings.
// ---------------------------------------------------------------------------
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    W_EPC,
    W_CAUSE,
    W_TVAL,
    W_STATUS,
    REDIRECT
  } state_e;

  typedef enum logic [1:0] {
    TGT_M,
    TGT_S,
    TGT_D
  } target_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;
  localparam logic [11:0] CSR_DCSR    = 12'h7B0;
  localparam logic [11:0] CSR_DPC     = 12'h7B1;

  localparam int MSTATUS_SIE    = 1;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_SPIE   = 5;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_SPP    = 8;
  localparam int MSTATUS_MPP_LO = 11;

  localparam int DCSR_CAUSE_LO = 6;
  localparam int DCSR_PRV_LO   = 0;

  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

endpackage

// File: rtl/trap_vector_calc.sv
// ---------------------------------------------------------------------------
// trap_vector_calc
// Combinational trap vector computation.
//   target_i   : selected trap target (M, S or debug)
//   tvec_i     : xtvec value of the selected target (mode in bits [1:0])
//   cause_lo_i : low six bits of the cause code, used as vector index
//   async_i    : trap is an interrupt
//   vec_pc_o   : PC the frontend is redirected to
// Vectored mode only applies to interrupts; synchronous exceptions always go
// to the base address. Debug entry ignores tvec and uses DEBUG_ENTRY.
// ---------------------------------------------------------------------------
module trap_vector_calc
  import trap_sequencer_pkg::*;
#(
  parameter int                XLEN        = 64,
  parameter logic [XLEN-1:0]   DEBUG_ENTRY = 'h800
) (
  input  target_e           target_i,
  input  logic [XLEN-1:0]   tvec_i,
  input  logic [5:0]        cause_lo_i,
  input  logic              async_i,
  output logic [XLEN-1:0]   vec_pc_o
);

  logic [XLEN-1:0] base;

  assign base = tvec_i & ~XLEN'(3);

  always_comb begin
    vec_pc_o = base;
    if (target_i == TGT_D) begin
      vec_pc_o = DEBUG_ENTRY;
    end else if (tvec_i[1:0] == 2'b01 && async_i) begin
      vec_pc_o = base + (XLEN'(cause_lo_i) << 2);
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
// Turns a trap decision from commit into its architectural side effects:
// a one-cycle pipeline flush, the CSR writes of trap entry over the shared
// CSR write port, then a privilege update together with a PC redirect.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   priv              : current privilege level
//   trap_valid/ready  : request handshake, ready only while idle
//   trap_m/s/d        : trap target decision (debug > M > S)
//   trap_cause/async/dcause/pc/tval : trap information, latched at accept
//   csr_mtvec/stvec/mstatus/dcsr    : CSR values, latched at accept
//   csr_we/waddr/wdata, csr_wready  : shared CSR write port
//   flush             : pipeline flush pulse
//   priv_we/priv_next : privilege update
//   debug_mode_set    : debug mode entry, pulses with priv_we
//   redirect_valid/pc : frontend redirect
//   busy              : sequence in progress
//
// Build option: define DEBUG_EN to honour trap_d and enable the debug entry
// path (DPC/DCSR writes, debug_mode_set). Without it trap_d and trap_dcause
// are ignored and debug_mode_set is tied low.
// ---------------------------------------------------------------------------
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] DEBUG_ENTRY = 'h800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        priv,
  input  logic              trap_m,
  input  logic              trap_s,
  input  logic              trap_d,
  input  logic              trap_valid,
  output logic              trap_ready,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic              trap_async,
  input  logic [2:0]        trap_dcause,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_tval,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_stvec,
  input  logic [XLEN-1:0]   csr_mstatus,
  input  logic [XLEN-1:0]   csr_dcsr,
  output logic              csr_we,
  output logic [11:0]       csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic              csr_wready,
  output logic              flush,
  output logic              priv_we,
  output logic [1:0]        priv_next,
  output logic              debug_mode_set,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy
);

  state_e            state_q, state_d;
  target_e           target_q;
  target_e           newTarget;
  logic              hasTarget;
  logic              accept;

  logic [XLEN-2:0]   cause_q;
  logic              async_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   tval_q;
  logic [1:0]        priv_q;
  logic [XLEN-1:0]   tvec_q;
  logic [XLEN-1:0]   mstatus_q;

  logic              flush_q, flush_d;
  logic              csrWe_q, csrWe_d;
  logic [11:0]       csrWaddr_q, csrWaddr_d;
  logic [XLEN-1:0]   csrWdata_q, csrWdata_d;
  logic              privWe_q, privWe_d;
  logic [1:0]        privNext_q, privNext_d;
  logic              redirectValid_q, redirectValid_d;
  logic [XLEN-1:0]   redirectPc_q, redirectPc_d;

  logic [XLEN-1:0]   statusData;
  logic [XLEN-1:0]   vecPc;

`ifdef DEBUG_EN
  logic [2:0]        dcause_q;
  logic [XLEN-1:0]   dcsr_q;
  logic              debugSet_q, debugSet_d;
  logic              unused_bits;

  assign unused_bits = trap_cause[XLEN-1];
`else
  logic              unused_bits;

  assign unused_bits = ^{trap_cause[XLEN-1], trap_d, trap_dcause, csr_dcsr};
`endif

  // Target priority: debug beats machine beats supervisor. A request with
  // no target bit set is not a trap and is dropped.
  always_comb begin
    newTarget = trap_m ? TGT_M : TGT_S;
    hasTarget = trap_m | trap_s;
`ifdef DEBUG_EN
    if (trap_d) begin
      newTarget = TGT_D;
    end
    hasTarget = hasTarget | trap_d;
`endif
  end

  assign accept = trap_valid && (state_q == IDLE) && hasTarget;

  // Debug entry skips xCAUSE/xTVAL and goes straight from DPC to DCSR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = FLUSH;
      FLUSH:    state_d = W_EPC;
      W_EPC:    if (csr_wready) state_d = (target_q == TGT_D) ? W_STATUS : W_CAUSE;
      W_CAUSE:  if (csr_wready) state_d = W_TVAL;
      W_TVAL:   if (csr_wready) state_d = W_STATUS;
      W_STATUS: if (csr_wready) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // New status value: the previous interrupt enable is stacked, interrupts
  // are disabled and the trapping privilege is recorded.
  always_comb begin
    statusData = mstatus_q;
    case (target_q)
      TGT_S: begin
        statusData[MSTATUS_SPIE] = mstatus_q[MSTATUS_SIE];
        statusData[MSTATUS_SIE]  = 1'b0;
        statusData[MSTATUS_SPP]  = priv_q[0];
      end
`ifdef DEBUG_EN
      TGT_D: begin
        statusData = dcsr_q;
        statusData[DCSR_CAUSE_LO +: 3] = dcause_q;
        statusData[DCSR_PRV_LO +: 2]   = priv_q;
      end
`endif
      default: begin
        statusData[MSTATUS_MPIE]      = mstatus_q[MSTATUS_MIE];
        statusData[MSTATUS_MIE]       = 1'b0;
        statusData[MSTATUS_MPP_LO +: 2] = priv_q;
      end
    endcase
  end

  trap_vector_calc #(
    .XLEN        (XLEN),
    .DEBUG_ENTRY (DEBUG_ENTRY)
  ) u_vector (
    .target_i   (target_q),
    .tvec_i     (tvec_q),
    .cause_lo_i (cause_q[5:0]),
    .async_i    (async_q),
    .vec_pc_o   (vecPc)
  );

  // Outputs are decoded from the state being entered, so they are registered
  // and appear in the same cycle as the state. A stalled write keeps the same
  // state and therefore the same address/data.
  always_comb begin
    flush_d         = (state_d == FLUSH);
    csrWe_d         = 1'b0;
    csrWaddr_d      = '0;
    csrWdata_d      = '0;
    redirectValid_d = (state_d == REDIRECT);
    privWe_d        = (state_d == REDIRECT);
    privNext_d      = '0;
    redirectPc_d    = '0;
    case (state_d)
      W_EPC: begin
        csrWe_d    = 1'b1;
        csrWaddr_d = (target_q == TGT_S) ? CSR_SEPC :
                     (target_q == TGT_D) ? CSR_DPC  : CSR_MEPC;
        csrWdata_d = (target_q == TGT_D) ? pc_q : (pc_q & ~XLEN'(1));
      end
      W_CAUSE: begin
        csrWe_d    = 1'b1;
        csrWaddr_d = (target_q == TGT_S) ? CSR_SCAUSE : CSR_MCAUSE;
        csrWdata_d = {async_q, cause_q};
      end
      W_TVAL: begin
        csrWe_d    = 1'b1;
        csrWaddr_d = (target_q == TGT_S) ? CSR_STVAL : CSR_MTVAL;
        csrWdata_d = async_q ? '0 : tval_q;
      end
      W_STATUS: begin
        csrWe_d    = 1'b1;
        csrWaddr_d = (target_q == TGT_S) ? CSR_SSTATUS :
                     (target_q == TGT_D) ? CSR_DCSR    : CSR_MSTATUS;
        csrWdata_d = statusData;
      end
      REDIRECT: begin
        privNext_d   = (target_q == TGT_S) ? PRIV_S : PRIV_M;
        redirectPc_d = vecPc;
      end
      default: ;
    endcase
  end

`ifdef DEBUG_EN
  assign debugSet_d = (state_d == REDIRECT) && (target_q == TGT_D);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      target_q        <= TGT_M;
      cause_q         <= '0;
      async_q         <= 1'b0;
      pc_q            <= '0;
      tval_q          <= '0;
      priv_q          <= '0;
      tvec_q          <= '0;
      mstatus_q       <= '0;
      flush_q         <= 1'b0;
      csrWe_q         <= 1'b0;
      csrWaddr_q      <= '0;
      csrWdata_q      <= '0;
      privWe_q        <= 1'b0;
      privNext_q      <= '0;
      redirectValid_q <= 1'b0;
      redirectPc_q    <= '0;
`ifdef DEBUG_EN
      dcause_q        <= '0;
      dcsr_q          <= '0;
      debugSet_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      flush_q         <= flush_d;
      csrWe_q         <= csrWe_d;
      csrWaddr_q      <= csrWaddr_d;
      csrWdata_q      <= csrWdata_d;
      privWe_q        <= privWe_d;
      privNext_q      <= privNext_d;
      redirectValid_q <= redirectValid_d;
      redirectPc_q    <= redirectPc_d;
`ifdef DEBUG_EN
      debugSet_q      <= debugSet_d;
`endif
      if (accept) begin
        target_q  <= newTarget;
        cause_q   <= trap_cause[XLEN-2:0];
        async_q   <= trap_async;
        pc_q      <= trap_pc;
        tval_q    <= trap_tval;
        priv_q    <= priv;
        // Only the tvec of the chosen target is ever needed.
        tvec_q    <= (newTarget == TGT_S) ? csr_stvec : csr_mtvec;
        mstatus_q <= csr_mstatus;
`ifdef DEBUG_EN
        dcause_q  <= trap_dcause;
        dcsr_q    <= csr_dcsr;
`endif
      end
    end
  end

  assign trap_ready     = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign flush          = flush_q;
  assign csr_we         = csrWe_q;
  assign csr_waddr      = csrWaddr_q;
  assign csr_wdata      = csrWdata_q;
  assign priv_we        = privWe_q;
  assign priv_next      = privNext_q;
  assign redirect_valid = redirectValid_q;
  assign redirect_pc    = redirectPc_q;
`ifdef DEBUG_EN
  assign debug_mode_set = debugSet_q;
`else
  assign debug_mode_set = 1'b0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
// Directed bench for trap_sequencer. Each scenario pushes the expected flush,
// CSR writes and redirect (with the cycle each must appear in, counted from
// the accept edge) into a queue; every clock the observed events are popped
// and compared. Builds with or without DEBUG_EN.
// ---------------------------------------------------------------------------
module tb_trap_sequencer;

  localparam int EV_NONE  = 0;
  localparam int EV_FLUSH = 1;
  localparam int EV_WRITE = 2;
  localparam int EV_REDIR = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [11:0] addr;
    logic [63:0] data;
    logic [1:0]  prv;
    logic        dbg;
    string       tag;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [1:0]  priv;
  logic        trap_m, trap_s, trap_d, trap_valid, trap_ready;
  logic [63:0] trap_cause;
  logic        trap_async;
  logic [2:0]  trap_dcause;
  logic [63:0] trap_pc, trap_tval;
  logic [63:0] csr_mtvec, csr_stvec, csr_mstatus, csr_dcsr;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        csr_wready;
  logic        flush, priv_we, debug_mode_set, redirect_valid, busy;
  logic [1:0]  priv_next;
  logic [63:0] redirect_pc;

  ev_t expQ[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  stallN = 0;
  int  rstAt = 0;
  int  pulseAt = 0;
  int  expReadyAt = 1;

  trap_sequencer #(
    .XLEN        (64),
    .DEBUG_ENTRY (64'h800)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .priv           (priv),
    .trap_m         (trap_m),
    .trap_s         (trap_s),
    .trap_d         (trap_d),
    .trap_valid     (trap_valid),
    .trap_ready     (trap_ready),
    .trap_cause     (trap_cause),
    .trap_async     (trap_async),
    .trap_dcause    (trap_dcause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .csr_mtvec      (csr_mtvec),
    .csr_stvec      (csr_stvec),
    .csr_mstatus    (csr_mstatus),
    .csr_dcsr       (csr_dcsr),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_wready     (csr_wready),
    .flush          (flush),
    .priv_we        (priv_we),
    .priv_next      (priv_next),
    .debug_mode_set (debug_mode_set),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushEvent(input int kind, input int c, input logic [11:0] addr,
                           input logic [63:0] data, input logic [1:0] prv,
                           input logic dbg, input string tag);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = addr;
    e.data = data;
    e.prv  = prv;
    e.dbg  = dbg;
    e.tag  = tag;
    expQ.push_back(e);
  endtask

  task automatic checkEvent(input int kind, input int n);
    ev_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_event", 64'(kind), 64'(EV_NONE));
      return;
    end
    e = expQ.pop_front();
    checkOutput({e.tag, "_kind"}, 64'(kind), 64'(e.kind));
    checkOutput({e.tag, "_cycle"}, 64'(n), 64'(e.cyc));
    if (kind == EV_WRITE && e.kind == EV_WRITE) begin
      checkOutput({e.tag, "_addr"}, 64'(csr_waddr), 64'(e.addr));
      checkOutput({e.tag, "_data"}, csr_wdata, e.data);
    end
    if (kind == EV_REDIR && e.kind == EV_REDIR) begin
      checkOutput({e.tag, "_pc"}, redirect_pc, e.data);
      checkOutput({e.tag, "_priv_next"}, 64'(priv_next), 64'(e.prv));
      checkOutput({e.tag, "_priv_we"}, 64'(priv_we), 64'(1));
      checkOutput({e.tag, "_debug_set"}, 64'(debug_mode_set), 64'(e.dbg));
    end
  endtask

  // One clock: drive per-cycle controls for the coming edge, then observe.
  task automatic stepCycle();
    int n;
    @(posedge clk);
    #1;
    cyc++;
    n = cyc - t0;
    trap_valid = (pulseAt > 0) && (n == pulseAt);
    rst        = (rstAt > 0) && (n == rstAt);
    csr_wready = !(n >= 3 && n < 3 + stallN);
    checkOutput("trap_ready", 64'(trap_ready), 64'(n >= expReadyAt));
    checkOutput("busy", 64'(busy), 64'(n < expReadyAt));
    if (flush) checkEvent(EV_FLUSH, n);
    if (csr_we && csr_wready) checkEvent(EV_WRITE, n);
    if (csr_we && !csr_wready && expQ.size() > 0) begin
      checkOutput("stall_addr", 64'(csr_waddr), 64'(expQ[0].addr));
      checkOutput("stall_data", csr_wdata, expQ[0].data);
    end
    if (redirect_valid) checkEvent(EV_REDIR, n);
  endtask

  task automatic applyStimulus(input string name,
                               input logic tm, input logic ts, input logic td,
                               input logic [1:0] prv, input logic [63:0] cause,
                               input logic async, input logic [2:0] dc,
                               input logic [63:0] pc, input logic [63:0] tval,
                               input logic [63:0] mtvec, input logic [63:0] stvec,
                               input logic [63:0] mstatus, input logic [63:0] dcsr,
                               input int stall, input int rstCycle, input int pulseCycle);
    int          tgt;
    int          lim;
    int          nw;
    int          c;
    logic [11:0] addrs[4];
    logic [63:0] datas[4];
    logic [63:0] tvec;
    logic [63:0] st;
    logic [63:0] target;

    tgt = -1;
    if (ts) tgt = 1;
    if (tm) tgt = 0;
`ifdef DEBUG_EN
    if (td) tgt = 2;
`endif
    lim = (rstCycle > 0) ? rstCycle : 1000;
    expReadyAt = 1;

    if (tgt >= 0) begin
      pushEvent(EV_FLUSH, 1, 12'h0, 64'h0, 2'd0, 1'b0, {name, "_flush"});
      if (tgt == 2) begin
        nw = 2;
        addrs[0] = 12'h7B1; datas[0] = pc;
        st = dcsr;
        st[8:6] = dc;
        st[1:0] = prv;
        addrs[1] = 12'h7B0; datas[1] = st;
        target = 64'h800;
      end else begin
        nw = 4;
        addrs[0] = (tgt == 1) ? 12'h141 : 12'h341;
        addrs[1] = (tgt == 1) ? 12'h142 : 12'h342;
        addrs[2] = (tgt == 1) ? 12'h143 : 12'h343;
        addrs[3] = (tgt == 1) ? 12'h100 : 12'h300;
        datas[0] = pc & ~64'h1;
        datas[1] = {async, cause[62:0]};
        datas[2] = async ? 64'h0 : tval;
        st = mstatus;
        if (tgt == 1) begin
          st[5] = mstatus[1];
          st[1] = 1'b0;
          st[8] = prv[0];
        end else begin
          st[7] = mstatus[3];
          st[3] = 1'b0;
          st[12:11] = prv;
        end
        datas[3] = st;
        tvec = (tgt == 1) ? stvec : mtvec;
        target = tvec & ~64'h3;
        if (tvec[1:0] == 2'b01 && async) target = target + {56'h0, cause[5:0], 2'b00};
      end
      for (int i = 0; i < nw; i++) begin
        c = 2 + i + ((i >= 1) ? stall : 0);
        if (c <= lim) pushEvent(EV_WRITE, c, addrs[i], datas[i], 2'd0, 1'b0,
                                $sformatf("%s_w%0d", name, i));
      end
      c = 2 + nw + stall;
      if (c <= lim) pushEvent(EV_REDIR, c, 12'h0, target, (tgt == 1) ? 2'd1 : 2'd3,
                              tgt == 2, {name, "_redirect"});
      expReadyAt = (c + 1 < lim + 1) ? c + 1 : lim + 1;
    end

    stallN      = stall;
    rstAt       = rstCycle;
    pulseAt     = pulseCycle;
    trap_m      = tm;
    trap_s      = ts;
    trap_d      = td;
    priv        = prv;
    trap_cause  = cause;
    trap_async  = async;
    trap_dcause = dc;
    trap_pc     = pc;
    trap_tval   = tval;
    csr_mtvec   = mtvec;
    csr_stvec   = stvec;
    csr_mstatus = mstatus;
    csr_dcsr    = dcsr;
    t0          = cyc;
    trap_valid  = 1'b1;
    repeat (14) stepCycle();
  endtask

  initial begin
    rst = 1'b1;
    priv = 2'd0;
    trap_m = 1'b0; trap_s = 1'b0; trap_d = 1'b0; trap_valid = 1'b0;
    trap_cause = '0; trap_async = 1'b0; trap_dcause = '0;
    trap_pc = '0; trap_tval = '0;
    csr_mtvec = '0; csr_stvec = '0; csr_mstatus = '0; csr_dcsr = '0;
    csr_wready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_trap_ready", 64'(trap_ready), 64'(1));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_flush", 64'(flush), 64'(0));
    checkOutput("reset_csr_we", 64'(csr_we), 64'(0));
    checkOutput("reset_csr_waddr", 64'(csr_waddr), 64'(0));
    checkOutput("reset_csr_wdata", csr_wdata, 64'(0));
    checkOutput("reset_priv_we", 64'(priv_we), 64'(0));
    checkOutput("reset_priv_next", 64'(priv_next), 64'(0));
    checkOutput("reset_redirect_valid", 64'(redirect_valid), 64'(0));
    checkOutput("reset_redirect_pc", redirect_pc, 64'(0));
    checkOutput("reset_debug_set", 64'(debug_mode_set), 64'(0));
    rst = 1'b0;
    cyc = 0;

    $display("[TB] U-mode illegal instruction to M, vectored mtvec");
    applyStimulus("m_illegal", 1'b1, 1'b0, 1'b0, 2'd0, 64'd2, 1'b0, 3'd0,
                  64'h1000, 64'hDEAD, 64'h8000_0001, 64'h0, 64'h1808, 64'h0, 0, 0, 0);

    $display("[TB] S-mode timer interrupt to S, vectored stvec");
    applyStimulus("s_timer", 1'b0, 1'b1, 1'b0, 2'd1, 64'd5, 1'b1, 3'd0,
                  64'h3003, 64'h1234, 64'h0, 64'h2001, 64'hA_0000_0002, 64'h0, 0, 0, 0);

    $display("[TB] M interrupt with csr_wready low during W_CAUSE");
    applyStimulus("m_stall", 1'b1, 1'b1, 1'b0, 2'd1, 64'd11, 1'b1, 3'd0,
                  64'h4440, 64'h77, 64'h4001, 64'h9000, 64'h0000_0000_0000_0088, 64'h0, 3, 0, 0);

`ifdef DEBUG_EN
    $display("[TB] debug entry beats M target");
    applyStimulus("dbg", 1'b1, 1'b0, 1'b1, 2'd0, 64'd3, 1'b0, 3'd3,
                  64'h5001, 64'h0, 64'h100, 64'h0, 64'h8, 64'h4000_0003, 0, 0, 0);
`else
    $display("[TB] debug-only request is ignored without debug support");
    applyStimulus("dbg_off", 1'b0, 1'b0, 1'b1, 2'd0, 64'd3, 1'b0, 3'd3,
                  64'h5001, 64'h0, 64'h100, 64'h0, 64'h8, 64'h4000_0003, 0, 0, 0);
    applyStimulus("dbg_s", 1'b0, 1'b1, 1'b1, 2'd0, 64'd8, 1'b0, 3'd3,
                  64'h6004, 64'h55, 64'h0, 64'h6000, 64'h2, 64'h4000_0003, 0, 0, 0);
`endif

    $display("[TB] request with no target set is ignored");
    applyStimulus("no_target", 1'b0, 1'b0, 1'b0, 2'd3, 64'd1, 1'b0, 3'd0,
                  64'h7000, 64'h1, 64'h100, 64'h200, 64'h0, 64'h0, 0, 0, 0);

    $display("[TB] reset asserted in W_TVAL");
    applyStimulus("m_reset", 1'b1, 1'b0, 1'b0, 2'd3, 64'd7, 1'b0, 3'd0,
                  64'h8000, 64'hBEEF, 64'hC000, 64'h0, 64'h8, 64'h0, 0, 4, 0);

    $display("[TB] trap_valid pulsed while busy");
    applyStimulus("m_busy", 1'b1, 1'b0, 1'b0, 2'd1, 64'd13, 1'b0, 3'd0,
                  64'h9002, 64'h42, 64'hA000, 64'h0, 64'h800, 64'h0, 0, 0, 3);

    checkOutput("leftover_events", 64'(expQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
